// File: rtl/bridge_pkg.sv
// Shared definitions for the processor-to-timer bridge.
// Contents: FSM state encoding, timer register indices, default device bases.
package bridge_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_PRESET = 2'd1;
   localparam logic [1:0] REG_COUNT  = 2'd2;

   localparam logic [31:0] TIMER0_BASE_DEF = 32'h0000_7F00;
   localparam logic [31:0] TIMER1_BASE_DEF = 32'h0000_7F10;

endpackage

// File: rtl/addr_decode.sv
// Word-address decoder for the two timer windows.
// Ports:
//   addr  in  30  word address (byte address [31:2])
//   sel0  out  1  address falls in the timer 0 window
//   sel1  out  1  address falls in the timer 1 window
//   err   out  1  no window hit, or register index beyond COUNT
module addr_decode
   import bridge_pkg::*;
#(
   parameter logic [31:0] TIMER0_BASE = TIMER0_BASE_DEF,
   parameter logic [31:0] TIMER1_BASE = TIMER1_BASE_DEF
) (
   input  logic [29:0] addr,
   output logic        sel0,
   output logic        sel1,
   output logic        err
);

   assign sel0 = (addr[29:2] == TIMER0_BASE[31:4]);
   assign sel1 = (addr[29:2] == TIMER1_BASE[31:4]);
   // Index 3 is unmapped inside both windows, so a window hit can still be an error.
   assign err  = ~(sel0 | sel1) | (addr[1:0] > REG_COUNT);

endmodule

// File: rtl/dev_bridge.sv
// Bus initiator from the processor memory stage to the two timer peripherals.
// A single-cycle request is latched, driven to the device bus for one ACCESS
// cycle, and acknowledged in the following DONE cycle. Timer interrupts are
// registered into the hardware-interrupt vector.
// Ports:
//   CLK_I, RST_I               clock, async active-high reset
//   PrReq/PrAddr/PrWe/PrWD     processor request
//   PrBusy/PrAck/PrErr/PrRD    processor response
//   HWInt                      interrupt vector [7:2]
//   DEV_ADD/DEV_DAT/DEV_WE0/1  device bus outputs (registered)
//   DEV_DAT0/1, IRQ0/1         device read data and interrupts
//
// state  | meaning
// IDLE   | waiting for PrReq
// ACCESS | device bus driven, write enable pulses, read data captured
// DONE   | PrAck/PrErr presented to processor
module dev_bridge
   import bridge_pkg::*;
#(
   parameter logic [31:0] TIMER0_BASE = TIMER0_BASE_DEF,
   parameter logic [31:0] TIMER1_BASE = TIMER1_BASE_DEF
) (
   input  logic        CLK_I,
   input  logic        RST_I,
   input  logic        PrReq,
   input  logic [31:0] PrAddr,
   input  logic        PrWe,
   input  logic [31:0] PrWD,
   output logic        PrBusy,
   output logic        PrAck,
   output logic        PrErr,
   output logic [31:0] PrRD,
   output logic [5:0]  HWInt,
   output logic [1:0]  DEV_ADD,
   output logic [31:0] DEV_DAT,
   output logic        DEV_WE0,
   output logic        DEV_WE1,
   input  logic [31:0] DEV_DAT0,
   input  logic [31:0] DEV_DAT1,
   input  logic        IRQ0,
   input  logic        IRQ1
);

   state_t      state, state_nxt;
   logic [29:0] addr_q;
   logic        we_q;
   logic        sel0, sel1, err;
   logic        req_sel0, req_sel1, req_err;
   logic        accept;
   logic [1:0]  irq_q;

   // Decode of the latched address drives the response path.
   addr_decode #(.TIMER0_BASE(TIMER0_BASE), .TIMER1_BASE(TIMER1_BASE)) u_dec (
      .addr (addr_q),
      .sel0 (sel0),
      .sel1 (sel1),
      .err  (err)
   );

   // The write enables are flops set on entry to ACCESS, so they need the
   // decode of the incoming address one edge before it is latched.
   addr_decode #(.TIMER0_BASE(TIMER0_BASE), .TIMER1_BASE(TIMER1_BASE)) u_dec_req (
      .addr (PrAddr[31:2]),
      .sel0 (req_sel0),
      .sel1 (req_sel1),
      .err  (req_err)
   );

   assign accept = (state == IDLE) & PrReq;

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (PrReq) state_nxt = ACCESS;
         ACCESS:  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         addr_q  <= '0;
         we_q    <= 1'b0;
         DEV_DAT <= '0;
         DEV_WE0 <= 1'b0;
         DEV_WE1 <= 1'b0;
      end else if (accept) begin
         addr_q  <= PrAddr[31:2];
         we_q    <= PrWe;
         DEV_DAT <= PrWD;
         DEV_WE0 <= PrWe & req_sel0 & ~req_err;
         DEV_WE1 <= PrWe & req_sel1 & ~req_err;
      end else begin
         DEV_WE0 <= 1'b0;
         DEV_WE1 <= 1'b0;
      end
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) begin
         PrRD <= '0;
      end else if (state == ACCESS) begin
         if (we_q || err) PrRD <= '0;
         else if (sel0)   PrRD <= DEV_DAT0;
         else if (sel1)   PrRD <= DEV_DAT1;
         else             PrRD <= '0;
      end
   end

   always_ff @(posedge CLK_I or posedge RST_I) begin
      if (RST_I) irq_q <= 2'b00;
      else       irq_q <= {IRQ1, IRQ0};
   end

   assign DEV_ADD = addr_q[1:0];
   assign PrBusy  = (state != IDLE);
   assign PrAck   = (state == DONE);
   assign PrErr   = (state == DONE) & err;
   assign HWInt   = {4'b0000, irq_q};

endmodule

// File: tb/tb_dev_bridge.sv
module tb_dev_bridge;

   logic        CLK_I = 1'b0;
   logic        RST_I;
   logic        PrReq;
   logic [31:0] PrAddr;
   logic        PrWe;
   logic [31:0] PrWD;
   logic        PrBusy, PrAck, PrErr;
   logic [31:0] PrRD;
   logic [5:0]  HWInt;
   logic [1:0]  DEV_ADD;
   logic [31:0] DEV_DAT;
   logic        DEV_WE0, DEV_WE1;
   logic [31:0] DEV_DAT0, DEV_DAT1;
   logic        IRQ0, IRQ1;

   typedef struct {
      logic        err;
      logic [31:0] rd;
   } exp_t;

   exp_t exp_q[$];
   int   n_total = 0;
   int   n_pass  = 0;

   dev_bridge dut (
      .CLK_I    (CLK_I),
      .RST_I    (RST_I),
      .PrReq    (PrReq),
      .PrAddr   (PrAddr),
      .PrWe     (PrWe),
      .PrWD     (PrWD),
      .PrBusy   (PrBusy),
      .PrAck    (PrAck),
      .PrErr    (PrErr),
      .PrRD     (PrRD),
      .HWInt    (HWInt),
      .DEV_ADD  (DEV_ADD),
      .DEV_DAT  (DEV_DAT),
      .DEV_WE0  (DEV_WE0),
      .DEV_WE1  (DEV_WE1),
      .DEV_DAT0 (DEV_DAT0),
      .DEV_DAT1 (DEV_DAT1),
      .IRQ0     (IRQ0),
      .IRQ1     (IRQ1)
   );

   always #5 CLK_I = ~CLK_I;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Called 1 time unit after a rising edge in IDLE; returns 1 unit into ACCESS.
   task automatic start(input logic [31:0] a, input logic we, input logic [31:0] wd,
                        input logic push, input logic e_err, input logic [31:0] e_rd);
      exp_t e;
      if (push) begin
         e.err = e_err;
         e.rd  = e_rd;
         exp_q.push_back(e);
      end
      PrReq  = 1'b1;
      PrAddr = a;
      PrWe   = we;
      PrWD   = wd;
      @(posedge CLK_I); #1;
      PrReq  = 1'b0;
   endtask

   // From 1 unit into ACCESS, steps through DONE back to IDLE.
   task automatic finish(input string nm);
      @(posedge CLK_I); #1;
      chk({nm, "_done_we"}, {30'd0, DEV_WE1, DEV_WE0}, 32'd0);
      chk({nm, "_done_busy"}, PrBusy, 1);
      @(posedge CLK_I); #1;
      chk({nm, "_idle_busy"}, PrBusy, 0);
   endtask

   // Scoreboard monitor: every acknowledge must match the oldest expectation.
   always @(negedge CLK_I) begin
      if (!RST_I && PrAck) begin
         if (exp_q.size() == 0) begin
            chk("ack_unexpected", PrAck, 0);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("ack_err", PrErr, e.err);
            chk("ack_rd", PrRD, e.rd);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RST_I = 1'b0; PrReq = 1'b0; PrAddr = '0; PrWe = 1'b0; PrWD = '0;
      DEV_DAT0 = '0; DEV_DAT1 = '0; IRQ0 = 1'b0; IRQ1 = 1'b0;
      #1 RST_I = 1'b1;
      @(posedge CLK_I); #1;
      chk("rst_busy", PrBusy, 0);
      chk("rst_ack",  PrAck, 0);
      chk("rst_err",  PrErr, 0);
      chk("rst_rd",   PrRD, 0);
      chk("rst_add",  DEV_ADD, 0);
      chk("rst_dat",  DEV_DAT, 0);
      chk("rst_we",   {30'd0, DEV_WE1, DEV_WE0}, 0);
      chk("rst_hwint", HWInt, 0);
      RST_I = 1'b0;
      @(posedge CLK_I); #1;

      // Write timer0 CTRL
      start(32'h0000_7F00, 1'b1, 32'h0000_0009, 1'b1, 1'b0, 32'h0);
      chk("wr0_busy", PrBusy, 1);
      chk("wr0_add",  DEV_ADD, 0);
      chk("wr0_dat",  DEV_DAT, 32'h9);
      chk("wr0_we0",  DEV_WE0, 1);
      chk("wr0_we1",  DEV_WE1, 0);
      finish("wr0");
      chk("wr0_hold_add", DEV_ADD, 0);
      chk("wr0_hold_dat", DEV_DAT, 32'h9);

      // Read timer1 PRESET
      DEV_DAT0 = 32'h0000_ABCD;
      DEV_DAT1 = 32'h0000_1234;
      start(32'h0000_7F14, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_1234);
      chk("rd1_add", DEV_ADD, 1);
      chk("rd1_we",  {30'd0, DEV_WE1, DEV_WE0}, 0);
      finish("rd1");

      // Read timer0 index 3 -> error, zero data despite nonzero device data
      start(32'h0000_7F0C, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0);
      chk("rderr_we", {30'd0, DEV_WE1, DEV_WE0}, 0);
      finish("rderr");

      // Write to unmapped address -> error, no write enable
      start(32'h0000_8000, 1'b1, 32'h5555_AAAA, 1'b1, 1'b1, 32'h0);
      chk("wrerr_we", {30'd0, DEV_WE1, DEV_WE0}, 0);
      finish("wrerr");

      // Read timer0 COUNT
      DEV_DAT0 = 32'h0000_55AA;
      start(32'h0000_7F08, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_55AA);
      chk("rd0c_add", DEV_ADD, 2);
      finish("rd0c");

      // Write timer1 CTRL
      start(32'h0000_7F10, 1'b1, 32'h0000_0003, 1'b1, 1'b0, 32'h0);
      chk("wr1_we1", DEV_WE1, 1);
      chk("wr1_we0", DEV_WE0, 0);
      finish("wr1");

      // Requests during ACCESS and DONE are ignored
      DEV_DAT0 = 32'h0000_0077;
      start(32'h0000_7F00, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0077);
      PrReq = 1'b1; PrWe = 1'b1; PrAddr = 32'h0000_7F10; PrWD = 32'h0000_DEAD;
      @(posedge CLK_I); #1;
      chk("ign_done_we1", DEV_WE1, 0);
      chk("ign_done_dat", DEV_DAT, 0);
      @(posedge CLK_I); #1;
      PrReq = 1'b0;
      chk("ign_idle_busy", PrBusy, 0);
      chk("ign_idle_we1", DEV_WE1, 0);
      start(32'h0000_7F10, 1'b1, 32'h0000_DEAD, 1'b1, 1'b0, 32'h0);
      chk("b2b_we1", DEV_WE1, 1);
      chk("b2b_dat", DEV_DAT, 32'h0000_DEAD);
      finish("b2b");

      // Interrupt registration
      IRQ1 = 1'b1;
      chk("irq_pre", HWInt, 0);
      @(posedge CLK_I); #1;
      chk("irq1", HWInt, 6'b000010);
      IRQ0 = 1'b1;
      @(posedge CLK_I); #1;
      chk("irq01", HWInt, 6'b000011);
      IRQ0 = 1'b0;
      @(posedge CLK_I); #1;
      chk("irq1_again", HWInt, 6'b000010);

      // Reset during ACCESS of a write: aborted, no acknowledge
      start(32'h0000_7F00, 1'b1, 32'h0000_0005, 1'b0, 1'b0, 32'h0);
      chk("abort_we0_pre", DEV_WE0, 1);
      #2 RST_I = 1'b1;
      #1;
      chk("abort_we0", DEV_WE0, 0);
      chk("abort_busy", PrBusy, 0);
      chk("abort_hwint", HWInt, 0);
      chk("abort_dat", DEV_DAT, 0);
      @(posedge CLK_I); #1;
      RST_I = 1'b0;
      @(posedge CLK_I); #1;
      chk("post_busy", PrBusy, 0);
      chk("post_ack", PrAck, 0);
      chk("post_we0", DEV_WE0, 0);
      chk("post_hwint", HWInt, 6'b000010);
      DEV_DAT1 = 32'h0000_CAFE;
      start(32'h0000_7F14, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_CAFE);
      chk("post_add", DEV_ADD, 1);
      finish("post");

      repeat (3) @(posedge CLK_I);
      #1;
      chk("ack_missing", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
